// File: rtl/countdown_arbiter.sv
// countdown_arbiter: shares one seconds countdown timer among N_REQ requesters.
// Requests are latched, granted round-robin without preemption, and the timeout returns to the owner as o_done.
module countdown_arbiter #(
  parameter int N_REQ  = 3,
  parameter int TIME_W = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        i_req,
  input  logic [N_REQ*TIME_W-1:0] i_req_sec,
  input  logic [N_REQ-1:0]        i_cancel,
  input  logic                    i_pause,
  input  logic                    i_timer_timeout,
  input  logic [TIME_W-1:0]       i_timer_val,
  output logic                    o_timer_start,
  output logic                    o_timer_en,
  output logic [TIME_W-1:0]       o_timer_sw,
  output logic [N_REQ-1:0]        o_grant,
  output logic [N_REQ-1:0]        o_done,
  output logic [N_REQ-1:0]        o_aborted,
  output logic                    o_busy,
  output logic [TIME_W-1:0]       o_owner_val
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [N_REQ-1:0]    pending;
  logic [N_REQ-1:0]    pending_nxt;
  logic [TIME_W-1:0]   sec_q [N_REQ];
  logic [PTR_W-1:0]    rr_ptr;
  logic [PTR_W-1:0]    rr_ptr_nxt;
  logic [N_REQ-1:0]    grant_nxt;
  logic [N_REQ-1:0]    grant_clr;
  logic [N_REQ-1:0]    aborted_nxt;
  logic [N_REQ-1:0]    eligible;
  logic [TIME_W-1:0]   sw_nxt;
  logic [PTR_W-1:0]    winner_idx;
  logic                winner_vld;
  logic [PTR_W:0]      cand;
  logic                owner_cancel;

  // The job is owned from LOAD through RUN; a cancel in DONE is too late to abort it.
  assign owner_cancel = ((state == LOAD) || (state == RUN)) && (|(i_cancel & o_grant));

  // A requester cancelled this cycle is not a grant candidate, even if it re-requests.
  assign eligible = pending & ~i_cancel;

  always_comb begin
    winner_vld = 1'b0;
    winner_idx = '0;
    cand       = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = {1'b0, rr_ptr} + (PTR_W+1)'(i);
      if (cand >= (PTR_W+1)'(N_REQ)) cand = cand - (PTR_W+1)'(N_REQ);
      if (!winner_vld && eligible[cand[PTR_W-1:0]]) begin
        winner_vld = 1'b1;
        winner_idx = cand[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    grant_nxt  = o_grant;
    grant_clr  = '0;
    sw_nxt     = o_timer_sw;
    rr_ptr_nxt = rr_ptr;
    case (state)
      IDLE: begin
        if (winner_vld) begin
          state_nxt             = LOAD;
          grant_nxt             = '0;
          grant_nxt[winner_idx] = 1'b1;
          grant_clr             = grant_nxt;
          sw_nxt                = sec_q[winner_idx];
          rr_ptr_nxt            = (winner_idx == PTR_W'(N_REQ - 1)) ? '0 : winner_idx + PTR_W'(1);
        end
      end
      LOAD: begin
        if (owner_cancel) begin
          state_nxt = IDLE;
          grant_nxt = '0;
        end else if (o_timer_sw == '0) begin
          state_nxt = DONE;
        end else begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        // Cancel beats a coincident timeout: the owner asked to abandon the job.
        if (owner_cancel) begin
          state_nxt = IDLE;
          grant_nxt = '0;
        end else if (i_timer_timeout) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  // A new request always re-arms, so it is applied after the grant and cancel clears.
  assign pending_nxt = (pending & ~grant_clr & ~i_cancel) | i_req;
  assign aborted_nxt = i_cancel & (pending | (owner_cancel ? o_grant : '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pending    <= '0;
      rr_ptr     <= '0;
      o_grant    <= '0;
      o_timer_sw <= '0;
      o_aborted  <= '0;
      for (int k = 0; k < N_REQ; k++) sec_q[k] <= '0;
    end else begin
      state      <= state_nxt;
      pending    <= pending_nxt;
      rr_ptr     <= rr_ptr_nxt;
      o_grant    <= grant_nxt;
      o_timer_sw <= sw_nxt;
      o_aborted  <= aborted_nxt;
      for (int k = 0; k < N_REQ; k++) begin
        if (i_req[k]) sec_q[k] <= i_req_sec[k*TIME_W +: TIME_W];
      end
    end
  end

  assign o_timer_start = (state == LOAD);
  assign o_timer_en    = (state == RUN) && !i_pause;
  assign o_done        = (state == DONE) ? o_grant : '0;
  assign o_busy        = (state != IDLE);
  assign o_owner_val   = ((state == RUN) || (state == DONE)) ? i_timer_val : '0;

endmodule

// File: tb/tb_countdown_arbiter.sv
// Testbench for countdown_arbiter: behavioural seconds timer (4 clocks per second) plus a
// job-level reference model of the arbiter, directed scenarios and a randomized run.
module tb_countdown_arbiter;
  localparam int N = 3;
  localparam int TW = 4;
  localparam int CLK_FREQ = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    i_req = '0;
  logic [N*TW-1:0] i_req_sec = '0;
  logic [N-1:0]    i_cancel = '0;
  logic            i_pause = 1'b0;
  logic            t_timeout;
  logic [TW-1:0]   t_val;
  int              t_cnt;
  logic            o_timer_start, o_timer_en, o_busy;
  logic [TW-1:0]   o_timer_sw, o_owner_val;
  logic [N-1:0]    o_grant, o_done, o_aborted;
  logic [19:0]     dut_vec;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  countdown_arbiter #(.N_REQ(N), .TIME_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .i_req(i_req), .i_req_sec(i_req_sec), .i_cancel(i_cancel),
    .i_pause(i_pause), .i_timer_timeout(t_timeout), .i_timer_val(t_val),
    .o_timer_start(o_timer_start), .o_timer_en(o_timer_en), .o_timer_sw(o_timer_sw),
    .o_grant(o_grant), .o_done(o_done), .o_aborted(o_aborted), .o_busy(o_busy),
    .o_owner_val(o_owner_val)
  );

  assign dut_vec = {o_grant, o_done, o_aborted, o_busy, o_timer_start, o_timer_en, o_timer_sw, o_owner_val};

  // Seconds timer: load on start, one second per CLK_FREQ enabled clocks, registered timeout.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t_val <= '0; t_cnt <= 0; t_timeout <= 1'b0;
    end else begin
      t_timeout <= 1'b0;
      if (o_timer_start) begin
        t_val <= o_timer_sw; t_cnt <= 0;
      end else if (o_timer_en && t_val != 0) begin
        if (t_cnt == CLK_FREQ - 1) begin
          t_cnt <= 0;
          t_val <= t_val - 1'b1;
          if (t_val == 1) t_timeout <= 1'b1;
        end else begin
          t_cnt <= t_cnt + 1;
        end
      end
    end
  end

  // Reference model: phase 0 idle, 1 load, 2 run, 3 done; owner is a requester number.
  int       m_phase, m_owner, m_ptr, m_sw;
  int       m_sec [N];
  bit [N-1:0] m_pend, m_ab;

  task automatic model_reset();
    m_phase = 0; m_owner = -1; m_ptr = 0; m_sw = 0; m_pend = '0; m_ab = '0;
    for (int k = 0; k < N; k++) m_sec[k] = 0;
  endtask

  task automatic model_step();
    bit oc;
    bit [N-1:0] elig;
    int w;
    if (!rst_n) begin
      model_reset();
      return;
    end
    oc = (m_phase == 1 || m_phase == 2) && i_cancel[m_owner];
    for (int k = 0; k < N; k++) m_ab[k] = i_cancel[k] && (m_pend[k] || (oc && k == m_owner));
    elig = m_pend & ~i_cancel;
    if (m_phase == 0) begin
      w = -1;
      for (int j = 0; j < N; j++) if (w < 0 && elig[(m_ptr + j) % N]) w = (m_ptr + j) % N;
      if (w >= 0) begin
        m_owner = w; m_sw = m_sec[w]; m_pend[w] = 1'b0; m_ptr = (w + 1) % N; m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (oc) begin m_phase = 0; m_owner = -1; end
      else m_phase = (m_sw == 0) ? 3 : 2;
    end else if (m_phase == 2) begin
      if (oc) begin m_phase = 0; m_owner = -1; end
      else if (t_timeout) m_phase = 3;
    end else begin
      m_phase = 0; m_owner = -1;
    end
    for (int k = 0; k < N; k++) begin
      if (i_cancel[k]) m_pend[k] = 1'b0;
      if (i_req[k]) begin m_pend[k] = 1'b1; m_sec[k] = int'(i_req_sec[k*TW +: TW]); end
    end
  endtask

  function automatic logic [19:0] exp_vec();
    logic [N-1:0] g;
    g = '0;
    if (m_phase != 0) g[m_owner] = 1'b1;
    return {g, (m_phase == 3) ? g : 3'b000, m_ab, (m_phase != 0), (m_phase == 1),
            (m_phase == 2 && !i_pause), 4'(m_sw), (m_phase >= 2) ? t_val : 4'd0};
  endfunction

  // Advance the model over the coming edge, then apply new inputs and settle.
  task automatic drive(input logic [N-1:0] r, input logic [N*TW-1:0] s, input logic [N-1:0] c, input logic p);
    model_step();
    @(negedge clk);
    i_req = r; i_req_sec = s; i_cancel = c; i_pause = p;
    #1;
  endtask

  task automatic idle();
    drive('0, '0, '0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) idle();
    rst_n = 1'b1;
  endtask

  task automatic wait_grant(output logic [N-1:0] g);
    int n;
    g = '0; n = 0;
    while (n < 200 && g == '0) begin idle(); n++; g = o_grant; end
  endtask

  task automatic wait_done(output logic [N-1:0] d, output int n_en, output int n_cyc);
    d = '0; n_en = 0; n_cyc = 0;
    while (n_cyc < 400 && d == '0) begin
      idle(); n_cyc++;
      d = o_done;
      if (o_timer_en) n_en++;
    end
  endtask

  task automatic test_reset();
    model_reset();
    repeat (3) idle();
    tests++; if (dut_vec !== 20'h0) begin fails++; $display("FAIL reset_hold: got %h expected %h", dut_vec, 20'h0); end
    rst_n = 1'b1;
    idle();
    tests++; if (dut_vec !== 20'h0) begin fails++; $display("FAIL reset_release: got %h expected %h", dut_vec, 20'h0); end
  endtask

  task automatic test_single();
    logic [N-1:0] d; int n_en, n_cyc;
    drive(3'b010, 12'h030, '0, 1'b0);
    idle();
    tests++; if (o_grant !== 3'b000 || o_busy !== 1'b0) begin fails++; $display("FAIL single_pending: got grant %b busy %b expected 000 0", o_grant, o_busy); end
    idle();
    tests++; if ({o_grant, o_timer_start, o_timer_en, o_timer_sw, o_owner_val} !== {3'b010, 1'b1, 1'b0, 4'd3, 4'd0}) begin
      fails++; $display("FAIL single_load: got grant %b start %b en %b sw %0d val %0d expected 010 1 0 3 0", o_grant, o_timer_start, o_timer_en, o_timer_sw, o_owner_val);
    end
    wait_done(d, n_en, n_cyc);
    tests++; if (d !== 3'b010) begin fails++; $display("FAIL single_done: got %b expected 010", d); end
    // 12 counting edges plus the cycle in which the registered timeout is presented
    tests++; if (n_en !== 4 * 3 + 1) begin fails++; $display("FAIL single_en_cycles: got %0d expected %0d", n_en, 4 * 3 + 1); end
    tests++; if (o_grant !== 3'b010 || o_timer_en !== 1'b0) begin fails++; $display("FAIL single_done_state: got grant %b en %b expected 010 0", o_grant, o_timer_en); end
    idle();
    tests++; if (o_grant !== 3'b000 || o_busy !== 1'b0 || o_done !== 3'b000) begin fails++; $display("FAIL single_idle: got grant %b busy %b done %b expected 000 0 000", o_grant, o_busy, o_done); end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] g, d; int n_en, n_cyc;
    do_reset();
    drive(3'b101, 12'h111, '0, 1'b0);
    wait_grant(g);
    tests++; if (g !== 3'b001) begin fails++; $display("FAIL rr_first: got %b expected 001", g); end
    wait_done(d, n_en, n_cyc);
    tests++; if (d !== 3'b001) begin fails++; $display("FAIL rr_first_done: got %b expected 001", d); end
    idle();
    tests++; if (o_grant !== 3'b000 || o_busy !== 1'b0) begin fails++; $display("FAIL rr_gap: got grant %b busy %b expected 000 0", o_grant, o_busy); end
    idle();
    tests++; if (o_grant !== 3'b100) begin fails++; $display("FAIL rr_second: got %b expected 100", o_grant); end
    wait_done(d, n_en, n_cyc);
    tests++; if (d !== 3'b100) begin fails++; $display("FAIL rr_second_done: got %b expected 100", d); end
    drive(3'b011, 12'h111, '0, 1'b0);
    wait_grant(g);
    tests++; if (g !== 3'b001) begin fails++; $display("FAIL rr_wrap: got %b expected 001", g); end
    wait_done(d, n_en, n_cyc);
    wait_grant(g);
    tests++; if (g !== 3'b010) begin fails++; $display("FAIL rr_next: got %b expected 010", g); end
    wait_done(d, n_en, n_cyc);
    tests++; if (d !== 3'b010) begin fails++; $display("FAIL rr_next_done: got %b expected 010", d); end
  endtask

  task automatic test_owner_cancel();
    logic [N-1:0] g; int n; bit seen;
    drive(3'b001, 12'h005, '0, 1'b0);
    wait_grant(g);
    idle();
    drive('0, '0, 3'b100, 1'b0);
    idle();
    tests++; if (o_aborted !== 3'b000 || o_grant !== 3'b001 || o_timer_en !== 1'b1) begin
      fails++; $display("FAIL cancel_other: got aborted %b grant %b en %b expected 000 001 1", o_aborted, o_grant, o_timer_en);
    end
    n = 0;
    while (n < 200 && o_owner_val != 4'd2) begin idle(); n++; end
    tests++; if (o_owner_val !== 4'd2) begin fails++; $display("FAIL cancel_reach_val: got %0d expected 2", o_owner_val); end
    drive('0, '0, 3'b001, 1'b0);
    idle();
    tests++; if ({o_aborted, o_grant, o_timer_en, o_busy, o_owner_val} !== {3'b001, 3'b000, 1'b0, 1'b0, 4'd0}) begin
      fails++; $display("FAIL cancel_owner: got aborted %b grant %b en %b busy %b val %0d expected 001 000 0 0 0", o_aborted, o_grant, o_timer_en, o_busy, o_owner_val);
    end
    idle();
    tests++; if (o_aborted !== 3'b000) begin fails++; $display("FAIL cancel_pulse_width: got %b expected 000", o_aborted); end
    seen = 1'b0;
    repeat (40) begin idle(); if (o_done != '0 || o_grant != '0) seen = 1'b1; end
    tests++; if (seen !== 1'b0) begin fails++; $display("FAIL cancel_no_done: got activity %b expected 0", seen); end
  endtask

  task automatic test_pause();
    logic [N-1:0] g, d; int n_en, base, c1, c2; logic [TW-1:0] v0;
    drive(3'b001, 12'h002, '0, 1'b0);
    wait_grant(g);
    wait_done(d, n_en, base);
    idle();
    drive(3'b001, 12'h002, '0, 1'b0);
    wait_grant(g);
    c1 = 0;
    while (c1 < 200 && o_owner_val != 4'd1) begin idle(); c1++; end
    drive('0, '0, '0, 1'b1);
    v0 = o_owner_val;
    tests++; if (o_timer_en !== 1'b0) begin fails++; $display("FAIL pause_en: got %b expected 0", o_timer_en); end
    for (int i = 1; i < 10; i++) begin
      drive('0, '0, '0, 1'b1);
      tests++; if (o_owner_val !== v0 || o_timer_en !== 1'b0) begin
        fails++; $display("FAIL pause_freeze: got val %0d en %b expected %0d 0", o_owner_val, o_timer_en, v0);
      end
    end
    wait_done(d, n_en, c2);
    tests++; if (d !== 3'b001) begin fails++; $display("FAIL pause_done: got %b expected 001", d); end
    tests++; if (c1 + 10 + c2 !== base + 10) begin fails++; $display("FAIL pause_delay: got %0d cycles expected %0d", c1 + 10 + c2, base + 10); end
  endtask

  task automatic test_zero_sec();
    logic [N-1:0] g;
    drive(3'b010, 12'h000, '0, 1'b0);
    wait_grant(g);
    tests++; if ({g, o_timer_start, o_timer_en, o_timer_sw} !== {3'b010, 1'b1, 1'b0, 4'd0}) begin
      fails++; $display("FAIL zero_load: got grant %b start %b en %b sw %0d expected 010 1 0 0", g, o_timer_start, o_timer_en, o_timer_sw);
    end
    idle();
    tests++; if (o_done !== 3'b010 || o_timer_en !== 1'b0) begin fails++; $display("FAIL zero_done: got done %b en %b expected 010 0", o_done, o_timer_en); end
    idle();
    tests++; if (o_grant !== 3'b000 || o_busy !== 1'b0) begin fails++; $display("FAIL zero_idle: got grant %b busy %b expected 000 0", o_grant, o_busy); end
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] g; bit seen;
    drive(3'b101, 12'h303, '0, 1'b0);
    wait_grant(g);
    repeat (5) idle();
    #2 rst_n = 1'b0;
    #1;
    tests++; if (dut_vec !== 20'h0) begin fails++; $display("FAIL reset_async: got %h expected %h", dut_vec, 20'h0); end
    repeat (2) idle();
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin idle(); if (o_done != '0 || o_grant != '0 || o_aborted != '0) seen = 1'b1; end
    tests++; if (seen !== 1'b0) begin fails++; $display("FAIL reset_pending_cleared: got activity %b expected 0", seen); end
  endtask

  task automatic test_random();
    logic [N-1:0] r, c; logic [N*TW-1:0] s; logic p; logic [19:0] e;
    do_reset();
    for (int n = 0; n < 800; n++) begin
      r = '0; c = '0; s = '0;
      for (int k = 0; k < N; k++) begin
        r[k] = ($urandom_range(0, 7) == 0);
        c[k] = ($urandom_range(0, 19) == 0);
        s[k*TW +: TW] = 4'($urandom_range(0, 3));
      end
      p = ($urandom_range(0, 9) == 0);
      drive(r, s, c, p);
      e = exp_vec();
      tests++; if (dut_vec !== e) begin fails++; $display("FAIL random_cycle%0d: got %h expected %h", n, dut_vec, e); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_owner_cancel();
    test_pause();
    test_zero_sec();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
